// File: rtl/ddr_scrub_engine_if.sv
// Scrub status bus plus AXI4 write channels (AW/W/B) between the scrub engine and its peers.
// The master side is the scrub engine; the slave side is the CSR/DDR-controller side.
interface ddr_scrub_engine_if;
    logic         scrb_enable;
    logic [63:0]  scrb_addr;
    logic [2:0]   scrb_state;
    logic         scrb_done;
    logic         scrb_err;

    logic [15:0]  awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;

    logic [15:0]  wid;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;

    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport master (
        input  scrb_enable,
        output scrb_addr, scrb_state, scrb_done, scrb_err,
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output scrb_enable,
        input  scrb_addr, scrb_state, scrb_done, scrb_err,
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ddr_scrub_engine.sv
// Zero-fills a DDR region with AXI4 write bursts, one outstanding; best case 1+BURST_LEN+1 cycles per burst.
// All outputs registered; any awready/wready/bvalid stall is absorbed and valids hold until their handshake.
module ddr_scrub_engine #(
    parameter logic [63:0] MAX_ADDR  = 64'h3_FFFF_FFFF,
    parameter int          BURST_LEN = 64,
    parameter logic [15:0] AXI_ID    = 16'h0
) (
    input  logic                clk,
    input  logic                rst,
    ddr_scrub_engine_if.master  bus
);

    localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN) * 64'd64;
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q,   state_d;
    logic [63:0] addr_q,    addr_d;
    logic        done_q,    done_d;
    logic        err_q,     err_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        wlast_q,   wlast_d;
    logic        bready_q,  bready_d;
    logic [7:0]  beat_q,    beat_d;

    logic [7:0]  beat_inc;
    logic [64:0] next_addr;
    logic        region_end;

    assign beat_inc   = beat_q + 8'd1;
    assign next_addr  = {1'b0, addr_q} + {1'b0, BURST_BYTES};
    // Widened compare so a region ending at the top of the address space cannot wrap.
    assign region_end = next_addr > {1'b0, MAX_ADDR};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        done_d    = done_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        beat_d    = beat_q;

        case (state_q)
            IDLE: begin
                if (bus.scrb_enable) begin
                    state_d   = ADDR;
                    addr_d    = '0;
                    err_d     = 1'b0;
                    done_d    = 1'b0;
                    awvalid_d = 1'b1;
                end
            end
            ADDR: begin
                if (bus.awready) begin
                    state_d   = DATA;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (LAST_BEAT == 8'd0);
                    beat_d    = '0;
                end
            end
            DATA: begin
                if (bus.wready) begin
                    if (wlast_q) begin
                        state_d  = RESP;
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        beat_d   = '0;
                        bready_d = 1'b1;
                    end else begin
                        beat_d  = beat_inc;
                        wlast_d = (beat_inc == LAST_BEAT);
                    end
                end
            end
            RESP: begin
                if (bus.bvalid) begin
                    bready_d = 1'b0;
                    err_d    = err_q | (bus.bresp != 2'b00);
                    // Enable is only consulted here, so an in-flight burst always completes.
                    if (region_end) begin
                        state_d = DONE;
                        done_d  = bus.scrb_enable;
                    end else begin
                        addr_d = next_addr[63:0];
                        if (bus.scrb_enable) begin
                            state_d   = ADDR;
                            awvalid_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.scrb_enable) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            beat_q    <= beat_d;
        end
    end

    assign bus.scrb_addr  = addr_q;
    assign bus.scrb_state = state_q;
    assign bus.scrb_done  = done_q;
    assign bus.scrb_err   = err_q;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = LAST_BEAT;
    assign bus.awsize  = 3'b110;
    assign bus.awvalid = awvalid_q;

    assign bus.wid    = AXI_ID;
    assign bus.wdata  = '0;
    assign bus.wstrb  = '1;
    assign bus.wlast  = wlast_q;
    assign bus.wvalid = wvalid_q;

    assign bus.bready = bready_q;

endmodule

// File: tb/tb_ddr_scrub_engine.sv
// Directed bench for ddr_scrub_engine: a 4-beat/16 KiB instance and a 1-beat/256 B instance.
module tb_ddr_scrub_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    ddr_scrub_engine_if if1();
    ddr_scrub_engine_if if2();

    ddr_scrub_engine #(.MAX_ADDR(64'h3FFF), .BURST_LEN(4), .AXI_ID(16'h0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    ddr_scrub_engine #(.MAX_ADDR(64'hFF), .BURST_LEN(1), .AXI_ID(16'hA5)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bench-owned stimulus knobs (written only by the initial block)
    int epoch      = 0;
    bit stall      = 1'b0;
    int err_burst  = -1;

    // Monitor state (written only by the negedge block)
    int          seen_epoch = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int          aw2 = 0, w2 = 0;
    logic [63:0] exp_addr  = '0;
    logic [63:0] exp_addr2 = '0;
    bit          prev_awstall = 1'b0, prev_wstall = 1'b0;
    logic [63:0] prev_awaddr = '0;
    logic        prev_wlast  = 1'b0;

    // Inputs change on the falling edge; the values seen here are what the next rising edge samples.
    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch   = epoch;
            aw_cnt       = 0;
            w_cnt        = 0;
            b_cnt        = 0;
            exp_addr     = '0;
            prev_awstall = 1'b0;
            prev_wstall  = 1'b0;
        end
        if (stall) begin
            if1.awready = 1'($urandom_range(0, 1));
            if1.wready  = 1'($urandom_range(0, 1));
            if1.bvalid  = 1'($urandom_range(0, 1));
        end else begin
            if1.awready = 1'b1;
            if1.wready  = 1'b1;
            if1.bvalid  = 1'b1;
        end
        if1.bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        if2.awready = 1'b1;
        if2.wready  = 1'b1;
        if2.bvalid  = 1'b1;
        if2.bresp   = 2'b00;

        if (rst) begin
            prev_awstall = 1'b0;
            prev_wstall  = 1'b0;
        end else begin
            if (prev_awstall) begin
                chk("awvalid_hold", 64'(if1.awvalid), 64'd1);
                chk("awaddr_hold", if1.awaddr, prev_awaddr);
            end
            if (prev_wstall) begin
                chk("wvalid_hold", 64'(if1.wvalid), 64'd1);
                chk("wlast_hold", 64'(if1.wlast), 64'(prev_wlast));
            end
            if (if1.awvalid && if1.awready) begin
                chk("awaddr", if1.awaddr, exp_addr);
                exp_addr = exp_addr + 64'h100;
                aw_cnt++;
            end
            if (if1.wvalid && if1.wready) begin
                chk("wlast_every_4th", 64'(if1.wlast), 64'((w_cnt % 4) == 3));
                w_cnt++;
            end
            if (if1.bvalid && if1.bready) b_cnt++;
            prev_awstall = if1.awvalid && !if1.awready;
            prev_awaddr  = if1.awaddr;
            prev_wstall  = if1.wvalid && !if1.wready;
            prev_wlast   = if1.wlast;

            if (if2.awvalid && if2.awready) begin
                chk("bl1_awaddr", if2.awaddr, exp_addr2);
                exp_addr2 = exp_addr2 + 64'h40;
                aw2++;
            end
            if (if2.wvalid && if2.wready) begin
                chk("bl1_wlast", 64'(if2.wlast), 64'd1);
                w2++;
            end
        end
    end

    int cyc;

    initial begin
        rst = 1'b1;
        if1.scrb_enable = 1'b0;
        if2.scrb_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   64'(if1.scrb_state), 64'd0);
        chk("rst_addr",    if1.scrb_addr, 64'd0);
        chk("rst_done",    64'(if1.scrb_done), 64'd0);
        chk("rst_err",     64'(if1.scrb_err), 64'd0);
        chk("rst_awvalid", 64'(if1.awvalid), 64'd0);
        chk("rst_wvalid",  64'(if1.wvalid), 64'd0);
        chk("rst_wlast",   64'(if1.wlast), 64'd0);
        chk("rst_bready",  64'(if1.bready), 64'd0);
        chk("awlen",       64'(if1.awlen), 64'd3);
        chk("awsize",      64'(if1.awsize), 64'd6);
        chk("awid",        64'(if1.awid), 64'h0);
        chk("wstrb",       if1.wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wdata_zero",  64'(if1.wdata == '0), 64'd1);
        chk("bl1_awlen",   64'(if2.awlen), 64'd0);
        chk("bl1_wid",     64'(if2.wid), 64'hA5);
        rst = 1'b0;

        // Full scrub, no stalls: 64 bursts x 6 cycles
        epoch++;
        if1.scrb_enable = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!if1.scrb_done && cyc < 2000);
        chk("clean_done_cycles", 64'(cyc), 64'd384);
        chk("clean_addr",  if1.scrb_addr, 64'h3F00);
        chk("clean_aw",    64'(aw_cnt), 64'd64);
        chk("clean_beats", 64'(w_cnt), 64'd256);
        chk("clean_b",     64'(b_cnt), 64'd64);
        chk("clean_err",   64'(if1.scrb_err), 64'd0);
        chk("clean_state", 64'(if1.scrb_state), 64'd4);
        if1.scrb_enable = 1'b0;
        @(posedge clk); #1;
        chk("done_clear",  64'(if1.scrb_done), 64'd0);
        chk("done_idle",   64'(if1.scrb_state), 64'd0);
        chk("done_addr_held", if1.scrb_addr, 64'h3F00);

        // Full scrub under random stalls
        epoch++;
        stall = 1'b1;
        if1.scrb_enable = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!if1.scrb_done && cyc < 8000);
        chk("stall_done",  64'(if1.scrb_done), 64'd1);
        chk("stall_aw",    64'(aw_cnt), 64'd64);
        chk("stall_beats", 64'(w_cnt), 64'd256);
        chk("stall_b",     64'(b_cnt), 64'd64);
        chk("stall_addr",  if1.scrb_addr, 64'h3F00);
        if1.scrb_enable = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;

        // Error response on burst index 10 only
        epoch++;
        err_burst = 10;
        if1.scrb_enable = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!if1.scrb_done && cyc < 2000);
        chk("berr_done", 64'(if1.scrb_done), 64'd1);
        chk("berr_err",  64'(if1.scrb_err), 64'd1);
        chk("berr_aw",   64'(aw_cnt), 64'd64);
        if1.scrb_enable = 1'b0;
        @(posedge clk); #1;
        chk("berr_err_held", 64'(if1.scrb_err), 64'd1);
        epoch++;
        err_burst = -1;
        if1.scrb_enable = 1'b1;
        @(posedge clk); #1;
        chk("restart_err_clr", 64'(if1.scrb_err), 64'd0);
        chk("restart_state",   64'(if1.scrb_state), 64'd1);
        chk("restart_addr",    if1.scrb_addr, 64'd0);
        if1.scrb_enable = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (if1.scrb_state != 3'd0 && cyc < 50);
        chk("short_abort_aw",   64'(aw_cnt), 64'd1);
        chk("short_abort_addr", if1.scrb_addr, 64'h100);

        // Enable dropped during beat 2 of burst index 4
        epoch++;
        if1.scrb_enable = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (w_cnt != 18 && cyc < 500);
        chk("abort_reach_beat", 64'(w_cnt), 64'd18);
        if1.scrb_enable = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (if1.scrb_state != 3'd0 && cyc < 100);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_aw",    64'(aw_cnt), 64'd5);
        chk("abort_beats", 64'(w_cnt), 64'd20);
        chk("abort_b",     64'(b_cnt), 64'd5);
        chk("abort_addr",  if1.scrb_addr, 64'h500);
        chk("abort_done",  64'(if1.scrb_done), 64'd0);
        chk("abort_state", 64'(if1.scrb_state), 64'd0);

        // Reset during DATA of burst index 2
        epoch++;
        if1.scrb_enable = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (w_cnt != 9 && cyc < 500);
        chk("mrst_reach_beat", 64'(w_cnt), 64'd9);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_awvalid", 64'(if1.awvalid), 64'd0);
        chk("mrst_wvalid",  64'(if1.wvalid), 64'd0);
        chk("mrst_wlast",   64'(if1.wlast), 64'd0);
        chk("mrst_bready",  64'(if1.bready), 64'd0);
        chk("mrst_state",   64'(if1.scrb_state), 64'd0);
        chk("mrst_addr",    if1.scrb_addr, 64'd0);
        rst = 1'b0;
        epoch++;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (aw_cnt < 1 && cyc < 50);
        chk("mrst_restart_aw", 64'(aw_cnt), 64'd1);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!if1.scrb_done && cyc < 2000);
        chk("mrst_full_aw", 64'(aw_cnt), 64'd64);
        if1.scrb_enable = 1'b0;
        @(posedge clk); #1;

        // Single-beat bursts over 256 bytes
        if2.scrb_enable = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!if2.scrb_done && cyc < 200);
        chk("bl1_done_cycles", 64'(cyc), 64'd12);
        chk("bl1_aw",    64'(aw2), 64'd4);
        chk("bl1_beats", 64'(w2), 64'd4);
        chk("bl1_addr",  if2.scrb_addr, 64'hC0);
        chk("bl1_err",   64'(if2.scrb_err), 64'd0);
        if2.scrb_enable = 1'b0;
        @(posedge clk); #1;
        chk("bl1_idle",  64'(if2.scrb_state), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_scrub_engine.md
Name: ddr_scrub_engine

Overview:
Memory-initialisation engine that drives the scrub status bus on its master side and writes zeros across a DDR region via AXI4 write channels, one burst outstanding at a time.
Sits between the CL scrub control/status register (upstream: enable, downstream: addr/state/done) and one DDR controller AXI slave port (write channels only; read channels tied off elsewhere).

Parameters:
MAX_ADDR, 64'h3_FFFF_FFFF, last byte address to scrub; MAX_ADDR+1 must be a multiple of BURST_BYTES.
BURST_LEN, 64, beats per burst (1..256); BURST_BYTES = BURST_LEN*64; awlen = BURST_LEN-1.
AXI_ID, 16'h0, constant value driven on awid and wid.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
scrb_enable  in  1  level request to scrub; sampled every cycle
scrb_addr  out  64  address of current/last burst
scrb_state  out  3  FSM state encoding (below)
scrb_done  out  1  full region scrubbed; held while scrb_enable=1
scrb_err  out  1  sticky: any bresp!=0 seen since scrub start
awid  out  16  = AXI_ID
awaddr  out  64  burst address, = scrb_addr
awlen  out  8  = BURST_LEN-1
awsize  out  3  = 3'b110 (64 B)
awvalid  out  1  write address valid
awready  in  1  write address ready
wid  out  16  = AXI_ID
wdata  out  512  all zeros
wstrb  out  64  all ones
wlast  out  1  final beat of burst
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response code
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- States/encoding: IDLE=0, ADDR=1, DATA=2, RESP=3, DONE=4. All registered outputs; no combinational input->output paths.
- Reset: state IDLE, scrb_addr=0, scrb_done=0, scrb_err=0, awvalid=0, wvalid=0, wlast=0, bready=0, beat counter 0. Reset mid-burst abandons the transaction immediately (system-level reset of DDR port assumed coincident).
- IDLE: scrb_enable=1 -> ADDR next cycle, scrb_addr=0, scrb_err cleared.
- ADDR: awvalid=1 until awready sampled high; then awvalid=0, -> DATA. awaddr stable while awvalid=1.
- DATA: wvalid=1; beat counter increments on each wvalid&wready; wlast=1 exactly when counter=BURST_LEN-1; on that handshake wvalid=0, counter=0, -> RESP. BURST_LEN=1: wlast high on first beat.
- RESP: bready=1; on bvalid: scrb_err |= (bresp!=0); bready=0. Then: if scrb_addr+BURST_BYTES > MAX_ADDR -> DONE (scrb_addr holds last burst address); else scrb_addr += BURST_BYTES and -> ADDR if scrb_enable=1, -> IDLE if scrb_enable=0.
- Enable deassert mid-burst: in-flight burst (AW, all W beats, B) always completes; abort decision made only at RESP exit. scrb_done stays 0 on abort.
- DONE: scrb_done=1 while scrb_enable=1; scrb_enable=0 -> IDLE next cycle, scrb_done=0. scrb_addr and scrb_err held until next start.
- Latency: best case (ready/valid always high) one burst = 1 (ADDR) + BURST_LEN (DATA) + 1 (RESP) cycles.
- Backpressure: any number of awready/wready/bvalid low cycles tolerated; valids never drop before handshake.

Test Plan:
- MAX_ADDR=16'h3FFF, BURST_LEN=4, all readys high, bvalid same cycle as bready -> exactly 64 bursts, awaddr 0x0,0x100..0x3F00, 256 beats total, scrb_done=1 after 64*6 cycles from enable, scrb_addr=0x3F00.
- Same config, random awready/wready/bvalid stalls (50%) -> identical address/beat sequence, wlast only on every 4th beat, valids stable under stall.
- bresp=2'b10 on burst 10 only -> all 64 bursts still issued, scrb_err=1 at done; restart with enable toggle clears scrb_err to 0.
- Drop scrb_enable during DATA beat 2 of burst 5 -> remaining beats + B complete, state IDLE, scrb_done=0, no 6th AW issued.
- Assert rst during DATA of burst 3 -> next cycle all valids 0, state 0, scrb_addr=0; re-enable restarts at address 0.
- BURST_LEN=1, MAX_ADDR=16'hFF -> 4 single-beat bursts, wlast=1 on every beat, done after 12 cycles.
